led_anim_trigger: RTL
=====================

// Module: led_anim_trigger
// PURPOSE
//  Turns a raw pushbutton into the one-shot `active` request that drives LED_Animation.
//  - Synchronises and debounces the button.
//  - Converts each accepted press into a fixed-length `active` pulse.
//  - Enforces a cooldown so the animation is never re-requested while it is still playing.
//  - Sits between board I/O and LED_Animation.active; exposes busy/count status to the top level.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive stable synced samples required to accept a level change (>=1)
//  PULSE_CYCLES     10  clocks `active` is held high per accepted press (>=1)
//  COOLDOWN_CYCLES  50  clocks after pulse end during which presses are ignored (>=0)
//  CNT_W            8   width of trig_count
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      synchronous, active-high reset
//  btn_raw     in   1      asynchronous, bouncy pushbutton level (1 = pressed)
//  enable      in   1      1 = presses may be accepted; 0 = presses ignored
//  active      out  1      request to LED_Animation; high for exactly PULSE_CYCLES clocks
//  busy        out  1      high in PULSE or COOLDOWN state
//  trig_count  out  CNT_W  number of accepted presses since reset; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (sampled high at a clock edge); all values hold at that edge and while reset stays high:
//  - sync flops = 0, btn_clean = 0, debounce counter = 0, state = IDLE.
//  - active = 0, busy = 0, trig_count = 0.
//  - Reset mid-PULSE or mid-COOLDOWN aborts immediately; no partial pulse resumes.
//  Synchroniser: 2-flop chain btn_raw -> s1 -> s2; only s2 is used downstream.
//  Debounce:
//  - db_cnt increments each clock that s2 != btn_clean.
//  - db_cnt clears to 0 on any clock where s2 == btn_clean.
//  - When s2 != btn_clean and db_cnt == DEBOUNCE_CYCLES-1: btn_clean <= s2 and db_cnt <= 0.
//  - Net: btn_clean follows a stable btn_raw change DEBOUNCE_CYCLES+2 clocks after the first
//    edge that samples the new level.
//  - Any glitch shorter than DEBOUNCE_CYCLES synced clocks never reaches btn_clean.
//  Press event: press = btn_clean & ~btn_clean_d (rising edge only, 1-cycle).
//  - A held button produces exactly one press.
//  - Release and re-press is required to produce another.
//  FSM (registered; outputs decoded from state):
//  - IDLE: active=0, busy=0.
//    - press & enable -> PULSE; load tmr = PULSE_CYCLES-1; trig_count <= trig_count+1.
//    - press & !enable -> stay IDLE; the press is dropped, not queued.
//  - PULSE: active=1, busy=1.
//    - tmr decrements each clock.
//    - at tmr==0: -> COOLDOWN with tmr = COOLDOWN_CYCLES-1, or -> IDLE if COOLDOWN_CYCLES==0.
//    - enable changes and presses are ignored; the pulse always completes.
//  - COOLDOWN: active=0, busy=1.
//    - tmr decrements; at tmr==0 -> IDLE.
//    - presses here are discarded, not queued.
//    - a press edge landing on the same clock as COOLDOWN->IDLE is also discarded.
//  Latency: `active` rises on the clock after the press cycle, i.e. DEBOUNCE_CYCLES+3 edges after
//  btn_raw is first sampled high (stable).
//  Timing: active width = PULSE_CYCLES exactly; busy width = PULSE_CYCLES+COOLDOWN_CYCLES exactly.
//  Width rules:
//  - tmr sized $clog2(max(PULSE_CYCLES,COOLDOWN_CYCLES,2)).
//  - trig_count wraps from 2^CNT_W-1 to 0 without any flag.
// TESTING  (defaults, 10 ns clock)
//  1. reset=1 for 4 clk with btn_raw toggling -> active=0, busy=0, trig_count=0 throughout.
//  2. enable=1, btn_raw high 20 clk then low -> active high exactly 10 clk, rising 7 edges after
//     first high sample; busy high 60 clk; trig_count=1.
//  3. btn_raw pulses of 3 clk high / 3 clk low repeated 10x -> active never rises, trig_count=0.
//     Repeat case 2 with enable=0 -> no pulse, trig_count=0.
//  4. Second clean press starting 20 clk into COOLDOWN -> ignored, trig_count stays 1.
//     Release, then press after busy falls -> second 10-clk pulse, trig_count=2.
//  5. Button held continuously for 200 clk -> exactly one pulse, trig_count=1, no retrigger at
//     cooldown end.
//  6. reset asserted on 5th clk of PULSE -> at that edge active=0, busy=0, trig_count=0.
//     Then a new press -> normal 10-clk pulse.

Source files
------------

// File: rtl/led_anim_trigger.sv
// Pushbutton front end for LED_Animation: synchronise, debounce, edge-detect, then issue a
// fixed-length `active` pulse followed by a cooldown during which further presses are dropped.
module led_anim_trigger #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 10,
  parameter int unsigned COOLDOWN_CYCLES = 50,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  input  logic             enable,
  output logic             active,
  output logic             busy,
  output logic [CNT_W-1:0] trig_count
);

  localparam int unsigned TmrSpan = (PULSE_CYCLES > COOLDOWN_CYCLES) ? PULSE_CYCLES
                                                                      : COOLDOWN_CYCLES;
  localparam int unsigned TmrW    = $clog2((TmrSpan < 2) ? 2 : TmrSpan);
  localparam int unsigned DbW     = $clog2((DEBOUNCE_CYCLES < 2) ? 2 : DEBOUNCE_CYCLES);

  localparam logic [TmrW-1:0] PulseLoad = TmrW'(PULSE_CYCLES - 1);
  localparam logic [TmrW-1:0] CoolLoad  = TmrW'((COOLDOWN_CYCLES == 0) ? 0
                                                                        : COOLDOWN_CYCLES - 1);
  localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPulse, StCooldown} state_e;

  logic             s1_q, s2_q;
  logic             btn_clean_q, btn_clean_d;
  logic             btn_clean_dly_q;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  state_e           state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q            <= 1'b0;
      s2_q            <= 1'b0;
      btn_clean_q     <= 1'b0;
      btn_clean_dly_q <= 1'b0;
      db_cnt_q        <= '0;
      state_q         <= StIdle;
      tmr_q           <= '0;
      cnt_q           <= '0;
    end else begin
      s1_q            <= btn_raw;
      s2_q            <= s1_q;
      btn_clean_q     <= btn_clean_d;
      btn_clean_dly_q <= btn_clean_q;
      db_cnt_q        <= db_cnt_d;
      state_q         <= state_d;
      tmr_q           <= tmr_d;
      cnt_q           <= cnt_d;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    btn_clean_d = btn_clean_q;
    db_cnt_d    = '0;
    if (s2_q != btn_clean_q) begin
      if (db_cnt_q == DbLast) begin
        btn_clean_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  assign press = btn_clean_q & ~btn_clean_dly_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (press && enable) begin
          state_d = StPulse;
          tmr_d   = PulseLoad;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      StPulse: begin
        if (tmr_q == '0) begin
          if (COOLDOWN_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StCooldown;
            tmr_d   = CoolLoad;
          end
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StCooldown: begin
        // A press coinciding with the return to idle is dropped, not carried over.
        if (tmr_q == '0) begin
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign active     = (state_q == StPulse);
  assign busy       = (state_q != StIdle);
  assign trig_count = cnt_q;

endmodule
